// File: rtl/msrh_l2_mem_responder.sv
// In-order L2 responder: requests queue in a small FIFO, are serviced one at a
// time against a line-wide backing memory, and answer after a fixed latency.
module msrh_l2_mem_responder #(
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      LATENCY   = 3,
    parameter int unsigned      MEM_WORDS = 1024,
    parameter int unsigned      DATA_W    = 128,
    parameter int unsigned      PADDR_W   = 32,
    parameter int unsigned      TAG_W     = 8,
    parameter int unsigned      CMD_W     = 2,
    parameter logic [CMD_W-1:0] M_XRD     = CMD_W'(0),
    parameter logic [CMD_W-1:0] M_XWR     = CMD_W'(1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  l2_req_valid_i,
    output logic                  l2_req_ready_o,
    input  logic [CMD_W-1:0]      l2_req_cmd_i,
    input  logic [PADDR_W-1:0]    l2_req_addr_i,
    input  logic [TAG_W-1:0]      l2_req_tag_i,
    input  logic [DATA_W-1:0]     l2_req_data_i,
    input  logic [DATA_W/8-1:0]   l2_req_byte_en_i,
    output logic                  l2_resp_valid_o,
    input  logic                  l2_resp_ready_i,
    output logic [TAG_W-1:0]      l2_resp_tag_o,
    output logic [DATA_W-1:0]     l2_resp_data_o
);
    localparam int unsigned DATA_B = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(DATA_B);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LAT_W  = $clog2(LATENCY + 1);

    // state  | meaning
    // S_IDLE | waiting for a queued request; pops head and performs writes
    // S_WAIT | latency countdown for the working request
    // S_RESP | response valid, held until l2_resp_ready_i
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [CMD_W-1:0]  fifo_cmd_q  [DEPTH];
    logic [IDX_W-1:0]  fifo_idx_q  [DEPTH];
    logic [TAG_W-1:0]  fifo_tag_q  [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_B-1:0] fifo_be_q   [DEPTH];
    logic [DATA_W-1:0] mem_q       [MEM_WORDS];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [CMD_W-1:0]  wk_cmd_q, wk_cmd_d;
    logic [IDX_W-1:0]  wk_idx_q, wk_idx_d;
    logic [TAG_W-1:0]  wk_tag_q, wk_tag_d;
    logic              resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              enq, deq, mem_we;
    logic              unused_addr_bits;

    // Offset and high address bits are ignored, so lines alias across the space.
    assign unused_addr_bits = ^l2_req_addr_i;

    assign l2_req_ready_o  = (count_q != CNT_W'(DEPTH));
    assign enq             = l2_req_valid_i && l2_req_ready_o;
    assign l2_resp_valid_o = resp_valid_q;
    assign l2_resp_tag_o   = resp_tag_q;
    assign l2_resp_data_o  = resp_data_q;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        wk_cmd_d     = wk_cmd_q;
        wk_idx_d     = wk_idx_q;
        wk_tag_d     = wk_tag_q;
        resp_valid_d = resp_valid_q;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        deq          = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    deq       = 1'b1;
                    mem_we    = (fifo_cmd_q[rd_ptr_q] == M_XWR);
                    wk_cmd_d  = fifo_cmd_q[rd_ptr_q];
                    wk_idx_d  = fifo_idx_q[rd_ptr_q];
                    wk_tag_d  = fifo_tag_q[rd_ptr_q];
                    lat_cnt_d = LAT_W'(LATENCY - 1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_tag_d   = wk_tag_q;
                    resp_data_d  = (wk_cmd_q == M_XRD) ? mem_q[wk_idx_q] : '0;
                    state_d      = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_RESP: begin
                if (l2_resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            lat_cnt_q    <= '0;
            wk_cmd_q     <= '0;
            wk_idx_q     <= '0;
            wk_tag_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            wk_cmd_q     <= wk_cmd_d;
            wk_idx_q     <= wk_idx_d;
            wk_tag_q     <= wk_tag_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) begin
            fifo_cmd_q[wr_ptr_q]  <= l2_req_cmd_i;
            fifo_idx_q[wr_ptr_q]  <= l2_req_addr_i[OFF_W +: IDX_W];
            fifo_tag_q[wr_ptr_q]  <= l2_req_tag_i;
            fifo_data_q[wr_ptr_q] <= l2_req_data_i;
            fifo_be_q[wr_ptr_q]   <= l2_req_byte_en_i;
        end
    end

    // Writes land at pop time, so any later read of the same line sees them.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(DATA_B); b++) begin
                if (fifo_be_q[rd_ptr_q][b])
                    mem_q[fifo_idx_q[rd_ptr_q]][b*8 +: 8] <= fifo_data_q[rd_ptr_q][b*8 +: 8];
            end
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (l2_resp_valid_o && !l2_resp_ready_i) |=> ($stable(l2_resp_tag_o) && $stable(l2_resp_data_o)));
    assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(enq && (count_q == CNT_W'(DEPTH))));
`endif

endmodule

// File: tb/tb_msrh_l2_mem_responder.sv
// Directed bench for msrh_l2_mem_responder: an in-order queue/line-memory model
// predicts every response, plus literal expectations for the key scenarios.
module tb_msrh_l2_mem_responder;
    localparam int DEPTH     = 4;
    localparam int LATENCY   = 3;
    localparam int MEM_WORDS = 1024;
    localparam int DATA_W    = 128;
    localparam int DATA_B    = DATA_W / 8;
    localparam int PADDR_W   = 32;
    localparam int TAG_W     = 8;
    localparam int CMD_W     = 2;
    localparam logic [1:0] RD  = 2'd0;
    localparam logic [1:0] WR  = 2'd1;
    localparam logic [1:0] BAD = 2'd2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid, req_ready;
    logic [CMD_W-1:0]    req_cmd;
    logic [PADDR_W-1:0]  req_addr;
    logic [TAG_W-1:0]    req_tag;
    logic [DATA_W-1:0]   req_data;
    logic [DATA_B-1:0]   req_be;
    logic                resp_valid, resp_ready;
    logic [TAG_W-1:0]    resp_tag;
    logic [DATA_W-1:0]   resp_data;

    msrh_l2_mem_responder #(
        .DEPTH(DEPTH), .LATENCY(LATENCY), .MEM_WORDS(MEM_WORDS), .DATA_W(DATA_W),
        .PADDR_W(PADDR_W), .TAG_W(TAG_W), .CMD_W(CMD_W), .M_XRD(RD), .M_XWR(WR)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .l2_req_valid_i(req_valid), .l2_req_ready_o(req_ready), .l2_req_cmd_i(req_cmd),
        .l2_req_addr_i(req_addr), .l2_req_tag_i(req_tag), .l2_req_data_i(req_data),
        .l2_req_byte_en_i(req_be),
        .l2_resp_valid_o(resp_valid), .l2_resp_ready_i(resp_ready),
        .l2_resp_tag_o(resp_tag), .l2_resp_data_o(resp_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DATA_W-1:0]       mdl_mem [int];
    logic [TAG_W+DATA_W-1:0] exp_q [$];
    int                      n_resp = 0;
    int                      acc_edge = 0;
    int                      rise_cyc = 0;
    logic [TAG_W-1:0]        last_tag;
    logic [DATA_W-1:0]       last_data;
    logic                    prev_valid = 1'b0;
    logic                    prev_stall = 1'b0;
    logic [TAG_W-1:0]        prev_tag;
    logic [DATA_W-1:0]       prev_data;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: each accepted request updates the line memory in order and
    // enqueues the response it must eventually produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && resp_valid) begin
                chk("stall_tag_stable", DATA_W'(resp_tag), DATA_W'(prev_tag));
                chk("stall_data_stable", resp_data, prev_data);
            end
            if (resp_valid && !prev_valid) rise_cyc = cyc;
            if (req_valid && req_ready) begin
                int idx;
                logic [DATA_W-1:0] line;
                idx = int'((req_addr / DATA_B) % MEM_WORDS);
                line = mdl_mem.exists(idx) ? mdl_mem[idx] : '0;
                acc_edge = cyc + 1;
                if (req_cmd == WR) begin
                    for (int b = 0; b < DATA_B; b++)
                        if (req_be[b]) line[b*8 +: 8] = req_data[b*8 +: 8];
                    mdl_mem[idx] = line;
                    exp_q.push_back({req_tag, {DATA_W{1'b0}}});
                end else if (req_cmd == RD) begin
                    exp_q.push_back({req_tag, line});
                end else begin
                    exp_q.push_back({req_tag, {DATA_W{1'b0}}});
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    logic [TAG_W+DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    chk("resp_tag", DATA_W'(resp_tag), DATA_W'(e[TAG_W+DATA_W-1:DATA_W]));
                    chk("resp_data", resp_data, e[DATA_W-1:0]);
                end
                last_tag  = resp_tag;
                last_data = resp_data;
                n_resp++;
            end
            prev_valid = resp_valid;
            prev_stall = resp_valid && !resp_ready;
            prev_tag   = resp_tag;
            prev_data  = resp_data;
        end
    end

    task automatic send(input logic [1:0] cmd, input logic [PADDR_W-1:0] addr, input logic [TAG_W-1:0] tag,
                        input logic [DATA_W-1:0] data, input logic [DATA_B-1:0] be);
        int n = 0;
        req_cmd = cmd; req_addr = addr; req_tag = tag; req_data = data; req_be = be;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_ready_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", DATA_W'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] a5, part, pat, ones;
        int k, n;
        a5   = {16{8'hA5}};
        part = {{15{8'hA5}}, 8'hFF};
        pat  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ones = '1;
        req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_tag = '0; req_data = '0; req_be = '0;
        resp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", DATA_W'(req_ready), 1);
        chk("reset_resp_valid", DATA_W'(resp_valid), 0);
        chk("reset_resp_tag", DATA_W'(resp_tag), 0);
        chk("reset_resp_data", resp_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full write then read from idle
        send(WR, 32'h1000, 8'd5, a5, '1);
        drain();
        chk("wr_resp_tag", DATA_W'(last_tag), 5);
        chk("wr_resp_data", last_data, 0);
        send(RD, 32'h1000, 8'd6, '0, '0);
        drain();
        chk("rd_resp_tag", DATA_W'(last_tag), 6);
        chk("rd_resp_data", last_data, a5);
        chk("rd_latency", DATA_W'(rise_cyc - acc_edge), LATENCY + 1);

        // single-byte write
        send(WR, 32'h1000, 8'd7, ones, 16'h0001);
        send(RD, 32'h1000, 8'd8, '0, '0);
        drain();
        chk("partial_data", last_data, part);

        // aliasing: high bits and line offset ignored
        send(RD, 32'h1000 + MEM_WORDS * DATA_B, 8'd9, '0, '0);
        drain();
        chk("alias_tag", DATA_W'(last_tag), 9);
        chk("alias_data", last_data, part);
        send(WR, 32'h2008, 8'd10, pat, '1);
        send(RD, 32'h6000, 8'd11, '0, '0);
        drain();
        chk("alias_offset_data", last_data, pat);

        // stall with a full FIFO
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'h30 + 8'(i);
            send((i % 2 == 1) ? RD : WR, 32'h3000, 8'(20 + i), {16{b}}, '1);
        end
        repeat (3) @(negedge clk);
        chk("full_ready_low", DATA_W'(req_ready), 0);
        chk("stall_head_valid", DATA_W'(resp_valid), 1);
        chk("stall_head_tag", DATA_W'(resp_tag), 20);
        @(posedge clk); #1;
        req_cmd = RD; req_tag = 8'd25; req_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_no_accept", DATA_W'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = n_resp;
        resp_ready = 1'b1;
        drain();
        chk("stall_resp_count", DATA_W'(n_resp - k), 5);
        chk("stall_last_tag", DATA_W'(last_tag), 24);

        // reset while waiting with two queued requests
        send(RD, 32'h1000, 8'd30, '0, '0);
        send(RD, 32'h1000, 8'd31, '0, '0);
        send(RD, 32'h1000, 8'd32, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_valid", DATA_W'(resp_valid), 0);
        chk("rst_wait_ready", DATA_W'(req_ready), 1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // reset while a response is stalled: valid must drop without a clock
        resp_ready = 1'b0;
        send(RD, 32'h1000, 8'd33, '0, '0);
        send(RD, 32'h1000, 8'd34, '0, '0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_valid", DATA_W'(resp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid_async", DATA_W'(resp_valid), 0);
        chk("rst_resp_ready", DATA_W'(req_ready), 1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        k = n_resp;
        repeat (20) @(negedge clk);
        chk("no_stale_resp", DATA_W'(n_resp - k), 0);
        @(posedge clk); #1;
        send(RD, 32'h1000, 8'd35, '0, '0);
        drain();
        chk("post_rst_count", DATA_W'(n_resp - k), 1);
        chk("post_rst_tag", DATA_W'(last_tag), 35);
        chk("post_rst_data", last_data, part);

        // unknown command: no memory effect, zero data
        send(BAD, 32'h1000, 8'd3, '0, '1);
        drain();
        chk("bad_cmd_tag", DATA_W'(last_tag), 3);
        chk("bad_cmd_data", last_data, 0);
        send(RD, 32'h1000, 8'd4, '0, '0);
        drain();
        chk("bad_cmd_mem_kept", last_data, part);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
